// File: rtl/mpa_mips_muldiv_pkg.sv
// rtl/mpa_mips_muldiv_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mpa_muldiv_pkg;

    localparam logic [1:0] MPA_OP_MULT  = 2'b00;
    localparam logic [1:0] MPA_OP_MULTU = 2'b01;
    localparam logic [1:0] MPA_OP_DIV   = 2'b10;
    localparam logic [1:0] MPA_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam int          MPA_MD_ITER  = 32;
    localparam logic [31:0] MPA_MD_DZ_LO = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand when it is to be treated as negative.
    function automatic logic [31:0] mpa_mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mpa_mips_muldiv_step.sv
// rtl/mpa_mips_muldiv_step.sv - one shift-add multiply or restoring divide iteration
module mpa_mips_muldiv_step (
    input  logic        is_div_i,
    input  logic [64:0] acc_i,
    input  logic [31:0] opd_i,
    output logic [64:0] acc_o
);

    logic [32:0] mul_sum;
    logic [64:0] div_sh;
    logic [33:0] div_diff;

    // Multiply: conditional add into the upper half then shift right; divide: shift left then trial subtract.
    always_comb begin
        mul_sum = acc_i[64:32];
        if (acc_i[0]) begin
            mul_sum = acc_i[64:32] + {1'b0, opd_i};
        end
        div_sh   = {acc_i[63:0], 1'b0};
        div_diff = {1'b0, div_sh[64:32]} - {2'b00, opd_i};
        if (is_div_i) begin
            acc_o = div_sh;
            if (!div_diff[33]) begin
                acc_o[64:32] = div_diff[32:0];
                acc_o[0]     = 1'b1;
            end
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/mpa_mips_muldiv.sv
// rtl/mpa_mips_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module mpa_mips_muldiv
    import mpa_muldiv_pkg::*;
(
    input  logic        HW_RSTn,
    input  logic        CLK,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [31:0] RS,
    input  logic [31:0] RT,
    input  logic        HI_WE,
    input  logic        LO_WE,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        DZ,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic        dz_pend_q;
    logic [64:0] acc_q;
    logic [64:0] acc_d;
    logic [31:0] opd_q;
    logic [31:0] rs_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;

    logic        st_is_div;
    logic        st_rs_neg;
    logic        st_rt_neg;
    logic [31:0] st_mag_rs;
    logic [31:0] st_mag_rt;
    logic [64:0] st_acc;
    logic [31:0] st_opd;

    logic [63:0] fix_prod;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    mpa_mips_muldiv_step u_step (
        .is_div_i (op_q[1]),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (acc_d)
    );

    // Operand setup at launch: signed ops work on magnitudes, the iterated operand sits in the low word.
    always_comb begin
        st_is_div = OP[1];
        st_rs_neg = ~OP[0] & RS[31];
        st_rt_neg = ~OP[0] & RT[31];
        st_mag_rs = mpa_mag(RS, st_rs_neg);
        st_mag_rt = mpa_mag(RT, st_rt_neg);
        if (st_is_div) begin
            st_acc = {33'd0, st_mag_rs};
            st_opd = st_mag_rt;
        end else begin
            st_acc = {33'd0, st_mag_rt};
            st_opd = st_mag_rs;
        end
    end

    // Sign correction and HI/LO selection applied in the FIX state.
    always_comb begin
        fix_prod = acc_q[63:0];
        fix_quo  = acc_q[31:0];
        fix_rem  = acc_q[63:32];
        if (op_q == MPA_OP_MULT && neg_res_q) begin
            fix_prod = ~acc_q[63:0] + 64'd1;
        end
        if (op_q == MPA_OP_DIV && neg_res_q) begin
            fix_quo = ~acc_q[31:0] + 32'd1;
        end
        if (op_q == MPA_OP_DIV && neg_rem_q) begin
            fix_rem = ~acc_q[63:32] + 32'd1;
        end
        if (op_q[1]) begin
            if (dz_pend_q) begin
                fix_hi = rs_q;
                fix_lo = MPA_MD_DZ_LO;
            end else begin
                fix_hi = fix_rem;
                fix_lo = fix_quo;
            end
        end else begin
            fix_hi = fix_prod[63:32];
            fix_lo = fix_prod[31:0];
        end
    end

    // Control FSM with registered HI/LO, BUSY, DONE and DZ.
    always_ff @(posedge CLK or negedge HW_RSTn) begin
        if (!HW_RSTn) begin
            state_q   <= MD_IDLE;
            cnt_q     <= 6'd0;
            op_q      <= MPA_OP_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
            acc_q     <= 65'd0;
            opd_q     <= 32'd0;
            rs_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (START) begin
                        op_q      <= OP;
                        neg_res_q <= st_rs_neg ^ st_rt_neg;
                        neg_rem_q <= st_rs_neg;
                        dz_pend_q <= st_is_div && (RT == 32'd0);
                        acc_q     <= st_acc;
                        opd_q     <= st_opd;
                        rs_q      <= RS;
                        cnt_q     <= 6'd0;
                        dz_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= MD_CALC;
                    end else begin
                        if (HI_WE) begin
                            hi_q <= WDATA;
                        end
                        if (LO_WE) begin
                            lo_q <= WDATA;
                        end
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(MPA_MD_ITER - 1)) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    dz_q    <= dz_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign DZ   = dz_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mpa_mips_muldiv.sv
// tb/tb_mpa_mips_muldiv.sv - self-checking bench for the HI/LO multiply/divide unit
module tb_mpa_mips_muldiv;

    logic        HW_RSTn;
    logic        CLK;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] RS;
    logic [31:0] RT;
    logic        HI_WE;
    logic        LO_WE;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        DZ;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int failures;

    mpa_mips_muldiv dut (
        .HW_RSTn (HW_RSTn),
        .CLK     (CLK),
        .START   (START),
        .OP      (OP),
        .RS      (RS),
        .RT      (RT),
        .HI_WE   (HI_WE),
        .LO_WE   (LO_WE),
        .WDATA   (WDATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DZ      (DZ),
        .HI      (HI),
        .LO      (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: ISA-level arithmetic on 64-bit integers.
    task automatic model(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        e_dz = 1'b0;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (op)
            2'b00: begin
                sp = sa * sb;
                e_hi = sp[63:32];
                e_lo = sp[31:0];
            end
            2'b01: begin
                up = 64'(rs) * 64'(rt);
                e_hi = up[63:32];
                e_lo = up[31:0];
            end
            default: begin
                if (rt == 32'd0) begin
                    e_dz = 1'b1;
                    e_hi = rs;
                    e_lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e_hi = sr[31:0];
                    e_lo = sq[31:0];
                end else begin
                    e_hi = rs % rt;
                    e_lo = rs / rt;
                end
            end
        endcase
    endtask

    // Launch one op from an idle negedge; returns at the negedge where DONE should be high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int inject, input bit start_we, input string tag);
        logic [31:0] e_hi, e_lo, hi_prev, lo_prev;
        logic        e_dz;
        int          busy_cnt;
        bit          held, early_done;
        model(op, rs, rt, e_hi, e_lo, e_dz);
        hi_prev = HI;
        lo_prev = LO;
        START = 1'b1;
        OP = op;
        RS = rs;
        RT = rt;
        if (start_we) begin
            HI_WE = 1'b1;
            LO_WE = 1'b1;
            WDATA = ~hi_prev;
        end
        @(negedge CLK);
        START = 1'b0;
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        OP = 2'($urandom);
        RS = $urandom;
        RT = $urandom;
        busy_cnt = 0;
        held = 1'b1;
        early_done = 1'b0;
        while (BUSY === 1'b1 && busy_cnt < 100) begin
            busy_cnt++;
            if (HI !== hi_prev || LO !== lo_prev) held = 1'b0;
            if (DONE !== 1'b0) early_done = 1'b1;
            if (busy_cnt == inject) begin
                START = 1'b1;
                OP = 2'($urandom);
                RS = ~rs;
                RT = rt + 32'd1;
                LO_WE = 1'b1;
                WDATA = 32'hA5A5_A5A5;
            end else begin
                START = 1'b0;
                LO_WE = 1'b0;
            end
            @(negedge CLK);
        end
        START = 1'b0;
        LO_WE = 1'b0;
        checks++;
        if (busy_cnt !== 33) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d exp 33", tag, busy_cnt);
        end
        checks++;
        if (!held || early_done) begin
            failures++;
            $display("FAIL %s hold_during_busy: held=%0d early_done=%0d exp 1/0", tag, held, early_done);
        end
        checks++;
        if (DONE !== 1'b1) begin
            failures++;
            $display("FAIL %s done: got %b exp 1", tag, DONE);
        end
        checks++;
        if (HI !== e_hi || LO !== e_lo) begin
            failures++;
            $display("FAIL %s hilo: got %h_%h exp %h_%h (op=%0d rs=%h rt=%h)", tag, HI, LO, e_hi, e_lo, op, rs, rt);
        end
        checks++;
        if (DZ !== e_dz) begin
            failures++;
            $display("FAIL %s dz: got %b exp %b", tag, DZ, e_dz);
        end
    endtask

    task automatic check_done_drops(input string tag);
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: DONE=%b BUSY=%b exp 0/0", tag, DONE, BUSY);
        end
    endtask

    task automatic test_reset();
        HW_RSTn = 1'b0;
        START = 1'b0;
        OP = 2'b00;
        RS = 32'd0;
        RT = 32'd0;
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        WDATA = 32'd0;
        repeat (3) @(negedge CLK);
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || DZ !== 1'b0) begin
            failures++;
            $display("FAIL reset: HI=%h LO=%h BUSY=%b DONE=%b DZ=%b exp all 0", HI, LO, BUSY, DONE, DZ);
        end
        HW_RSTn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mthi_mtlo();
        HI_WE = 1'b1;
        WDATA = 32'h1357_9BDF;
        @(negedge CLK);
        HI_WE = 1'b0;
        checks++;
        if (HI !== 32'h1357_9BDF || LO !== 32'd0) begin
            failures++;
            $display("FAIL mthi: HI=%h LO=%h exp 13579bdf/0", HI, LO);
        end
        LO_WE = 1'b1;
        WDATA = 32'h2468_ACE0;
        @(negedge CLK);
        LO_WE = 1'b0;
        checks++;
        if (HI !== 32'h1357_9BDF || LO !== 32'h2468_ACE0) begin
            failures++;
            $display("FAIL mtlo: HI=%h LO=%h exp 13579bdf/2468ace0", HI, LO);
        end
        HI_WE = 1'b1;
        LO_WE = 1'b1;
        WDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        HI_WE = 1'b0;
        LO_WE = 1'b0;
        checks++;
        if (HI !== 32'hDEAD_BEEF || LO !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mt_both: HI=%h LO=%h exp deadbeef/deadbeef", HI, LO);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, -1, 1'b0, "mult_neg");
        check_done_drops("mult_neg");
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, -1, 1'b0, "multu");
        check_done_drops("multu");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_neg");
        check_done_drops("div_neg");
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0, "divu");
        check_done_drops("divu");
        run_op(2'b10, 32'h0000_1234, 32'd0, -1, 1'b0, "div_zero");
        check_done_drops("div_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div_ovf");
        check_done_drops("div_ovf");
        run_op(2'b01, 32'd5, 32'd6, -1, 1'b0, "dz_clear");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            @(negedge CLK);
            run_op(op, a, b, -1, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, -1, 1'b0, "b2b_first");
        run_op(2'b11, 32'hFFFF_FFFF, 32'd10, -1, 1'b0, "b2b_second");
        check_done_drops("b2b_second");
    endtask

    task automatic test_boundary();
        run_op(2'b10, 32'hFFFF_FF00, 32'd9, 5, 1'b0, "start_mid_op");
        HI_WE = 1'b1;
        WDATA = 32'h0BAD_F00D;
        @(negedge CLK);
        HI_WE = 1'b0;
        checks++;
        if (HI !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL mthi_after_done: got %h exp 0badf00d", HI);
        end
        run_op(2'b01, 32'h0001_0001, 32'h0000_FFFF, -1, 1'b1, "start_with_we");
        check_done_drops("start_with_we");
    endtask

    task automatic test_reset_mid();
        bit saw_activity;
        START = 1'b1;
        OP = 2'b01;
        RS = 32'h1234_5678;
        RT = 32'h9ABC_DEF0;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        HW_RSTn = 1'b0;
        #1;
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || DZ !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: HI=%h LO=%h BUSY=%b DONE=%b DZ=%b exp all 0", HI, LO, BUSY, DONE, DZ);
        end
        @(negedge CLK);
        HW_RSTn = 1'b1;
        saw_activity = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) saw_activity = 1'b1;
        end
        checks++;
        if (saw_activity) begin
            failures++;
            $display("FAIL reset_mid_abort: activity after reset, DONE=%b BUSY=%b HI=%h LO=%h exp quiet", DONE, BUSY, HI, LO);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
